sobel_magnitude: RTL and testbench

- Downstream consumer of the 3x3 window line buffer.
- Takes each valid 72-bit window and computes the Sobel gradients Gx and Gy in a fixed 4-stage pipeline.
- Emits the approximate magnitude |Gx|+|Gy|, saturated to a pixel, plus a thresholded binary edge flag.
- Keeps a per-frame edge-pixel count for the display/debug path.

---
 rtl/sobel_pkg.sv | 40 ++++
 rtl/sobel_edge_counter.sv | 43 ++++
 rtl/sobel_magnitude.sv | 136 +++++++++++++
 tb/tb_sobel_magnitude.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared Sobel constants: default widths, window byte indices and slice helpers.
// The line buffer uses the same byte order when it packs windows.
package sobel_pkg;

  localparam int PIXEL_WIDTH_DEF = 8;
  localparam int GRAD_WIDTH_DEF  = 11;
  localparam int COUNT_WIDTH_DEF = 20;
  localparam int NUM_TAPS        = 9;

  // Window byte order: top L,C,R / mid L,C,R / bot L,C,R, byte 0 in the LSBs.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  localparam logic [PIXEL_WIDTH_DEF-1:0] PIX_MAX = '1;

  function automatic int sat_max(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic logic [PIXEL_WIDTH_DEF-1:0] win_pixel(
    input logic [NUM_TAPS*PIXEL_WIDTH_DEF-1:0] win,
    input int                                  idx
  );
    return win[idx*PIXEL_WIDTH_DEF +: PIXEL_WIDTH_DEF];
  endfunction

  function automatic logic [NUM_TAPS*PIXEL_WIDTH_DEF-1:0] win_pack(
    input logic [PIXEL_WIDTH_DEF-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8
  );
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

endpackage

// File: rtl/sobel_edge_counter.sv
// Per-frame edge accumulator: saturating count, reported and cleared on frame_start.
// An edge arriving in the frame_start cycle is credited to the frame that is ending.
module sobel_edge_counter
  import sobel_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_frame_start,
  input  logic                   i_edge,
  output logic [COUNT_WIDTH-1:0] o_edge_count,
  output logic                   o_edge_count_valid
);

  logic [COUNT_WIDTH-1:0] r_acc;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_count_valid;
  logic [COUNT_WIDTH-1:0] w_acc_inc;
  logic [COUNT_WIDTH-1:0] w_acc_next;

  assign w_acc_inc  = (r_acc == '1) ? r_acc : r_acc + COUNT_WIDTH'(1);
  assign w_acc_next = i_edge ? w_acc_inc : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
    end else if (i_frame_start) begin
      r_count       <= w_acc_next;
      r_count_valid <= 1'b1;
      r_acc         <= '0;
    end else begin
      r_count_valid <= 1'b0;
      r_acc         <= w_acc_next;
    end
  end

  assign o_edge_count       = r_count;
  assign o_edge_count_valid = r_count_valid;

endmodule

// File: rtl/sobel_magnitude.sv
// Four-stage Sobel datapath: column/row sums, gradients, |gx|+|gy|, saturate and threshold.
// No backpressure; each stage's data registers load only when that stage is valid.
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int GRAD_WIDTH  = GRAD_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            window_valid,
  input  logic [PIXEL_WIDTH*NUM_TAPS-1:0] window_in,
  input  logic                            frame_start,
  input  logic [PIXEL_WIDTH-1:0]          threshold,
  output logic                            pixel_valid_out,
  output logic [PIXEL_WIDTH-1:0]          pixel_out,
  output logic                            edge_out,
  output logic [COUNT_WIDTH-1:0]          edge_count,
  output logic                            edge_count_valid
);

  localparam int S1_W  = PIXEL_WIDTH + 2;
  localparam int MAG_W = GRAD_WIDTH + 1;
  localparam logic [MAG_W-1:0] SAT_MAX = MAG_W'(sat_max(PIXEL_WIDTH));

  logic [PIXEL_WIDTH-1:0] w_p [NUM_TAPS];

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_p[i] = window_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  logic r_v1, r_v2, r_v3, r_v4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else begin
      r_v1 <= window_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
    end
  end

  // Stage 1: weighted positive/negative sums for each gradient direction.
  logic [S1_W-1:0] w_xp, w_xn, w_yp, w_yn;
  logic [S1_W-1:0] r_xp, r_xn, r_yp, r_yn;

  assign w_xp = S1_W'(w_p[P2]) + (S1_W'(w_p[P5]) << 1) + S1_W'(w_p[P8]);
  assign w_xn = S1_W'(w_p[P0]) + (S1_W'(w_p[P3]) << 1) + S1_W'(w_p[P6]);
  assign w_yp = S1_W'(w_p[P6]) + (S1_W'(w_p[P7]) << 1) + S1_W'(w_p[P8]);
  assign w_yn = S1_W'(w_p[P0]) + (S1_W'(w_p[P1]) << 1) + S1_W'(w_p[P2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xp <= '0;
      r_xn <= '0;
      r_yp <= '0;
      r_yn <= '0;
    end else if (window_valid) begin
      r_xp <= w_xp;
      r_xn <= w_xn;
      r_yp <= w_yp;
      r_yn <= w_yn;
    end
  end

  logic signed [GRAD_WIDTH-1:0] r_gx, r_gy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gx <= '0;
      r_gy <= '0;
    end else if (r_v1) begin
      r_gx <= $signed(GRAD_WIDTH'(r_xp)) - $signed(GRAD_WIDTH'(r_xn));
      r_gy <= $signed(GRAD_WIDTH'(r_yp)) - $signed(GRAD_WIDTH'(r_yn));
    end
  end

  logic [GRAD_WIDTH-1:0] w_abs_gx, w_abs_gy;
  logic [MAG_W-1:0]      w_mag;
  logic [MAG_W-1:0]      r_mag;

  assign w_abs_gx = r_gx[GRAD_WIDTH-1] ? -r_gx : r_gx;
  assign w_abs_gy = r_gy[GRAD_WIDTH-1] ? -r_gy : r_gy;
  assign w_mag    = MAG_W'(w_abs_gx) + MAG_W'(w_abs_gy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag <= '0;
    end else if (r_v2) begin
      r_mag <= w_mag;
    end
  end

  // Stage 4: threshold is taken live in the cycle the result is registered.
  logic [PIXEL_WIDTH-1:0] w_sat;
  logic                   w_edge;
  logic [PIXEL_WIDTH-1:0] r_pix;
  logic                   r_edge;

  assign w_sat  = (r_mag > SAT_MAX) ? '1 : r_mag[PIXEL_WIDTH-1:0];
  assign w_edge = (w_sat > threshold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix  <= '0;
      r_edge <= 1'b0;
    end else if (r_v3) begin
      r_pix  <= w_sat;
      r_edge <= w_edge;
    end
  end

  assign pixel_valid_out = r_v4;
  assign pixel_out       = r_pix;
  assign edge_out        = r_edge;

  sobel_edge_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_edge_counter (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_frame_start      (frame_start),
    .i_edge             (r_v4 & r_edge),
    .o_edge_count       (edge_count),
    .o_edge_count_valid (edge_count_valid)
  );

endmodule

// File: tb/tb_sobel_magnitude.sv
// Bench for sobel_magnitude: directed windows, valid-pattern timing, frame statistics,
// reset mid-frame and randomized streams against a convolution-kernel reference model.
module tb_sobel_magnitude;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        window_valid;
  logic [71:0] window_in;
  logic        frame_start;
  logic [7:0]  threshold;
  logic        pixel_valid_out;
  logic [7:0]  pixel_out;
  logic        edge_out;
  logic [19:0] edge_count;
  logic        edge_count_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sobel_magnitude dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .window_valid     (window_valid),
    .window_in        (window_in),
    .frame_start      (frame_start),
    .threshold        (threshold),
    .pixel_valid_out  (pixel_valid_out),
    .pixel_out        (pixel_out),
    .edge_out         (edge_out),
    .edge_count       (edge_count),
    .edge_count_valid (edge_count_valid)
  );

  function automatic logic [71:0] mkwin(input logic [7:0] t0, t1, t2, m0, m1, m2, b0, b1, b2);
    return {b2, b1, b0, m2, m1, m0, t2, t1, t0};
  endfunction

  // Reference: correlate the window with the Sobel kernels, then saturate to a byte.
  function automatic int model_pix(input logic [71:0] w);
    int kx[9];
    int ky[9];
    int gx, gy, p, m;
    kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      p  = int'(w[i*8 +: 8]);
      gx = gx + kx[i] * p;
      gy = gy + ky[i] * p;
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic logic [71:0] rand_win(input int mode);
    logic [71:0] w;
    int base;
    base = $urandom_range(0, 255);
    for (int i = 0; i < 9; i++) begin
      case (mode)
        0:       w[i*8 +: 8] = 8'($urandom_range(0, 255));
        1:       w[i*8 +: 8] = 8'((base + $urandom_range(0, 20)) % 256);
        default: w[i*8 +: 8] = 8'(base);
      endcase
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [71:0] w);
    tick();
    window_valid = 1'b1;
    window_in    = w;
    tick();
    window_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    window_valid = 1'b0;
    window_in    = '0;
    frame_start  = 1'b0;
    threshold    = '0;
    repeat (3) tick();
    n_checks++;
    if ({pixel_valid_out, pixel_out, edge_out, edge_count, edge_count_valid} !== 31'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%0b pix=%0h edge=%0b cnt=%0d cv=%0b, expected all 0",
               pixel_valid_out, pixel_out, edge_out, edge_count, edge_count_valid);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [71:0] wins[6];
    logic [7:0]  thrs[6];
    logic [7:0]  exp_pix[6];
    logic        exp_edge[6];
    string       names[6];
    wins = '{72'h808080808080808080,
             mkwin(8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF),
             mkwin(8'h10, 8'h10, 8'h12, 8'h10, 8'h10, 8'h12, 8'h10, 8'h10, 8'h12),
             mkwin(8'h10, 8'h10, 8'h12, 8'h10, 8'h10, 8'h12, 8'h10, 8'h10, 8'h12),
             mkwin(8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00),
             mkwin(8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF)};
    thrs     = '{8'h10, 8'h40, 8'h08, 8'h07, 8'h40, 8'hFF};
    exp_pix  = '{8'h00, 8'hFF, 8'h08, 8'h08, 8'hFF, 8'hFF};
    exp_edge = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    names    = '{"flat", "vertical_edge", "small_thr8", "small_thr7", "negative_gy", "thr_ff"};
    for (int i = 0; i < 6; i++) begin
      threshold = thrs[i];
      send_one(wins[i]);
      n_checks++;
      if ({pixel_valid_out, pixel_out, edge_out} !== {1'b1, exp_pix[i], exp_edge[i]}) begin
        n_errors++;
        $display("FAIL %s: got v=%0b pix=%0h edge=%0b, expected v=1 pix=%0h edge=%0b",
                 names[i], pixel_valid_out, pixel_out, edge_out, exp_pix[i], exp_edge[i]);
      end
    end
    tick();
    n_checks++;
    if ({pixel_valid_out, pixel_out} !== {1'b0, 8'hFF}) begin
      n_errors++;
      $display("FAIL hold_after_valid: got v=%0b pix=%0h, expected v=0 pix=ff",
               pixel_valid_out, pixel_out);
    end
  endtask

  task automatic test_valid_pattern();
    logic        vp[6];
    logic [71:0] w[6];
    logic        ev;
    int          exp_pix;
    logic        exp_edge;
    vp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) w[i] = rand_win(1);
    threshold = 8'h20;
    exp_pix   = 0;
    exp_edge  = 1'b0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      tick();
      if (cyc >= 4) begin
        ev = (cyc - 4 < 6) ? vp[cyc-4] : 1'b0;
        if (ev) begin
          exp_pix  = model_pix(w[cyc-4]);
          exp_edge = (exp_pix > int'(threshold));
        end
        n_checks++;
        if ({pixel_valid_out, pixel_out, edge_out} !== {ev, 8'(exp_pix), exp_edge}) begin
          n_errors++;
          $display("FAIL valid_pattern slot %0d: got v=%0b pix=%0h edge=%0b, expected v=%0b pix=%0h edge=%0b",
                   cyc - 4, pixel_valid_out, pixel_out, edge_out, ev, 8'(exp_pix), exp_edge);
        end
      end
      window_valid = (cyc < 6) ? vp[cyc] : 1'b0;
      window_in    = (cyc < 6) ? w[cyc] : rand_win(0);
    end
    window_valid = 1'b0;
  endtask

  task automatic test_frame_stats_count();
    int pulses = 0;
    logic [71:0] vert;
    vert = mkwin(8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF);
    threshold = 8'h40;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int cyc = 0; cyc < 21; cyc++) begin
      tick();
      if (edge_count_valid) pulses++;
      if (cyc == 14) begin
        n_checks++;
        if ({pixel_valid_out, edge_out} !== 2'b11) begin
          n_errors++;
          $display("FAIL frame_same_cycle_edge: got v=%0b edge=%0b, expected 1 1",
                   pixel_valid_out, edge_out);
        end
      end
      if (cyc == 15) begin
        n_checks++;
        if ({edge_count_valid, edge_count} !== {1'b1, 20'd11}) begin
          n_errors++;
          $display("FAIL frame_count_11: got cv=%0b cnt=%0d, expected cv=1 cnt=11",
                   edge_count_valid, edge_count);
        end
      end
      window_valid = (cyc < 11);
      window_in    = vert;
      frame_start  = (cyc == 14);
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL frame_pulse_once: got %0d pulses, expected 1", pulses);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [71:0] vert;
    vert = mkwin(8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF);
    threshold = 8'h40;
    for (int cyc = 0; cyc < 7; cyc++) begin
      tick();
      window_valid = (cyc < 5);
      window_in    = vert;
    end
    window_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pixel_valid_out, pixel_out, edge_out, edge_count, edge_count_valid} !== 31'd0) begin
      n_errors++;
      $display("FAIL reset_mid_frame_outputs: got v=%0b pix=%0h edge=%0b cnt=%0d cv=%0b, expected all 0",
               pixel_valid_out, pixel_out, edge_out, edge_count, edge_count_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      window_valid = (cyc < 4);
      window_in    = vert;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if ({edge_count_valid, edge_count} !== {1'b1, 20'd4}) begin
      n_errors++;
      $display("FAIL reset_post_count: got cv=%0b cnt=%0d, expected cv=1 cnt=4",
               edge_count_valid, edge_count);
    end
  endtask

  task automatic test_frame_empty();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if ({edge_count_valid, edge_count} !== {1'b1, 20'd0}) begin
      n_errors++;
      $display("FAIL frame_empty: got cv=%0b cnt=%0d, expected cv=1 cnt=0",
               edge_count_valid, edge_count);
    end
  endtask

  task automatic test_random();
    logic [71:0] w_q[$];
    logic        v_q[$];
    logic [71:0] w;
    logic        v, ev;
    int          exp_pix;
    logic        exp_edge;
    int          exp_edges = 0;
    logic [7:0]  thr_tab[3];
    thr_tab = '{8'($urandom_range(0, 254)), 8'($urandom_range(0, 40)), 8'hFF};
    exp_pix  = 0;
    exp_edge = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int seg = 0; seg < 3; seg++) begin
      threshold = thr_tab[seg];
      w_q.delete();
      v_q.delete();
      for (int cyc = 0; cyc < 104; cyc++) begin
        tick();
        if (cyc >= 4) begin
          ev = v_q.pop_front();
          w  = w_q.pop_front();
          if (ev) begin
            exp_pix  = model_pix(w);
            exp_edge = (exp_pix > int'(threshold));
            if (exp_edge) exp_edges++;
          end
          n_checks++;
          if ({pixel_valid_out, pixel_out, edge_out} !== {ev, 8'(exp_pix), exp_edge}) begin
            n_errors++;
            $display("FAIL random seg %0d cyc %0d: got v=%0b pix=%0h edge=%0b, expected v=%0b pix=%0h edge=%0b",
                     seg, cyc, pixel_valid_out, pixel_out, edge_out, ev, 8'(exp_pix), exp_edge);
          end
        end
        v = (cyc == 0) ? 1'b1 : (cyc < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
        w = rand_win($urandom_range(0, 2));
        window_valid = v;
        window_in    = w;
        v_q.push_back(v);
        w_q.push_back(w);
      end
      window_valid = 1'b0;
    end
    frame_start = 1'b1;
    tick();
    n_checks++;
    if ({edge_count_valid, edge_count} !== {1'b1, 20'(exp_edges)}) begin
      n_errors++;
      $display("FAIL random_frame_count: got cv=%0b cnt=%0d, expected cv=1 cnt=%0d",
               edge_count_valid, edge_count, exp_edges);
    end
    tick();
    frame_start = 1'b0;
    n_checks++;
    if ({edge_count_valid, edge_count} !== {1'b1, 20'd0}) begin
      n_errors++;
      $display("FAIL back_to_back_frame_start: got cv=%0b cnt=%0d, expected cv=1 cnt=0",
               edge_count_valid, edge_count);
    end
    tick();
    n_checks++;
    if (edge_count_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL count_valid_drop: got cv=%0b, expected 0", edge_count_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_valid_pattern();
    test_frame_stats_count();
    test_reset_mid_frame();
    test_frame_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
